// File: rtl/p405s_icu_tag_arb.sv
// ICU tag array port owner: arbitrates flash-invalidate sweep > fill write > fetch lookup onto a single-ported array.
// Optional parity generation/check is enabled by defining P405S_ICU_TAG_PARITY_EN.
module p405s_icu_tag_arb #(
    parameter int SET_AW = 8,
    parameter int TAG_W  = 22
) (
    input  logic              CB,
    input  logic              reset,
    input  logic              lk_req,
    input  logic [SET_AW:0]   lk_idx,
    output logic              lk_gnt,
    output logic              lk_vld,
    output logic [TAG_W-1:0]  lk_tagA,
    output logic [TAG_W-1:0]  lk_tagB,
    output logic [1:0]        lk_par_err,
    input  logic              fill_req,
    input  logic [SET_AW:0]   fill_idx,
    input  logic              fill_wayA,
    input  logic [TAG_W-1:0]  fill_tag,
    output logic              fill_gnt,
    input  logic              inv_start,
    output logic              inv_busy,
    output logic              inv_done,
    output logic              tagCycle,
    output logic              readWr,
    output logic [SET_AW:0]   tagIndex,
    output logic [TAG_W:0]    writeTagANotB,
    output logic [TAG_W-1:0]  dataIn,
    output logic              dataInParityBit,
    input  logic [TAG_W-1:0]  tagAOut,
    input  logic [TAG_W-1:0]  tagBOut,
    input  logic              tagAOutParityBit,
    input  logic              tagBOutParityBit
);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

    state_t            state;
    logic [SET_AW-1:0] cnt;
    logic              phase;
    logic              arb_open;

    always_ff @(posedge CB or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            phase  <= 1'b0;
            lk_vld <= 1'b0;
        end else begin
            lk_vld <= lk_gnt;
            case (state)
                S_IDLE: begin
                    if (inv_start) begin
                        state <= S_SWEEP;
                        cnt   <= '0;
                        phase <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    // Way A then way B of each set; the last set ends the sweep instead of wrapping.
                    phase <= ~phase;
                    if (phase) begin
                        if (&cnt)
                            state <= S_DONE;
                        else
                            cnt <= cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign inv_busy = (state != S_IDLE);
    assign inv_done = (state == S_DONE);

    // Requests are only served while no sweep owns the port; grants are held off during reset.
    assign arb_open = (state == S_IDLE) && !reset;
    assign fill_gnt = arb_open && fill_req;
    assign lk_gnt   = arb_open && lk_req && !fill_req;

    assign lk_tagA = tagAOut;
    assign lk_tagB = tagBOut;

    always_comb begin
        tagCycle        = 1'b0;
        readWr          = 1'b1;
        tagIndex        = '0;
        writeTagANotB   = '1;
        dataIn          = '0;
        dataInParityBit = 1'b0;
        if (state == S_SWEEP && !reset) begin
            tagCycle      = 1'b1;
            readWr        = 1'b0;
            tagIndex      = {1'b0, cnt};
            writeTagANotB = {(TAG_W+1){~phase}};
        end else if (fill_gnt) begin
            tagCycle      = 1'b1;
            readWr        = 1'b0;
            tagIndex      = fill_idx;
            writeTagANotB = {(TAG_W+1){fill_wayA}};
            dataIn        = fill_tag;
`ifdef P405S_ICU_TAG_PARITY_EN
            dataInParityBit = ^fill_tag;
`endif
        end else if (lk_gnt) begin
            tagCycle = 1'b1;
            tagIndex = lk_idx;
        end
    end

`ifdef P405S_ICU_TAG_PARITY_EN
    assign lk_par_err[0] = lk_vld && (^{tagAOut, tagAOutParityBit});
    assign lk_par_err[1] = lk_vld && (^{tagBOut, tagBOutParityBit});
`else
    logic unused_par;
    assign unused_par = tagAOutParityBit ^ tagBOutParityBit;
    assign lk_par_err = 2'b00;
`endif

endmodule

// File: tb/tb_p405s_icu_tag_arb.sv
// Directed bench for p405s_icu_tag_arb with a behavioural single-ported tag array model.
module tb_p405s_icu_tag_arb;

    logic        CB = 1'b0;
    logic        reset = 1'b1;
    logic        lk_req = 1'b0;
    logic [8:0]  lk_idx = '0;
    logic        lk_gnt, lk_vld;
    logic [21:0] lk_tagA, lk_tagB;
    logic [1:0]  lk_par_err;
    logic        fill_req = 1'b0;
    logic [8:0]  fill_idx = '0;
    logic        fill_wayA = 1'b0;
    logic [21:0] fill_tag = '0;
    logic        fill_gnt;
    logic        inv_start = 1'b0;
    logic        inv_busy, inv_done;
    logic        tagCycle, readWr;
    logic [8:0]  tagIndex;
    logic [22:0] writeTagANotB;
    logic [21:0] dataIn;
    logic        dataInParityBit;
    logic [21:0] tagAOut, tagBOut;
    logic        tagAOutParityBit, tagBOutParityBit;

    int n_checks = 0;
    int n_fail   = 0;

    p405s_icu_tag_arb dut (
        .CB(CB), .reset(reset),
        .lk_req(lk_req), .lk_idx(lk_idx), .lk_gnt(lk_gnt), .lk_vld(lk_vld),
        .lk_tagA(lk_tagA), .lk_tagB(lk_tagB), .lk_par_err(lk_par_err),
        .fill_req(fill_req), .fill_idx(fill_idx), .fill_wayA(fill_wayA), .fill_tag(fill_tag),
        .fill_gnt(fill_gnt),
        .inv_start(inv_start), .inv_busy(inv_busy), .inv_done(inv_done),
        .tagCycle(tagCycle), .readWr(readWr), .tagIndex(tagIndex), .writeTagANotB(writeTagANotB),
        .dataIn(dataIn), .dataInParityBit(dataInParityBit),
        .tagAOut(tagAOut), .tagBOut(tagBOut),
        .tagAOutParityBit(tagAOutParityBit), .tagBOutParityBit(tagBOutParityBit)
    );

    always #5 CB = ~CB;

    // Tag array model: bit 22 holds parity; per-bit way select on writes.
    logic [22:0] mem_a [256];
    logic [22:0] mem_b [256];
    logic [22:0] rd_a = '0;
    logic [22:0] rd_b = '0;
    logic        mem_init = 1'b0;
    logic        flip_b = 1'b0;
    logic [22:0] wd;
    assign wd = {dataInParityBit, dataIn};

    always @(posedge CB) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 23'h155555 ^ 23'(i);
                mem_b[i] <= 23'h2AAAAA ^ 23'(i << 3);
            end
            mem_init <= 1'b1;
        end else if (tagCycle) begin
            if (readWr) begin
                rd_a <= mem_a[tagIndex[7:0]];
                rd_b <= mem_b[tagIndex[7:0]];
            end else begin
                mem_a[tagIndex[7:0]] <= (mem_a[tagIndex[7:0]] & ~writeTagANotB) | (wd & writeTagANotB);
                mem_b[tagIndex[7:0]] <= (mem_b[tagIndex[7:0]] & writeTagANotB) | (wd & ~writeTagANotB);
            end
        end
    end

    assign tagAOut          = rd_a[21:0];
    assign tagAOutParityBit = rd_a[22];
    assign tagBOut          = rd_b[21:0];
    assign tagBOutParityBit = rd_b[22] ^ flip_b;

`ifdef P405S_ICU_TAG_PARITY_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    task automatic test_reset();
        reset = 1'b1;
        fill_req = 1'b1; lk_req = 1'b1; fill_idx = 9'h0AB; lk_idx = 9'h0CD;
        repeat (2) @(negedge CB);
        #1;
        n_checks++; if (fill_gnt !== 1'b0 || lk_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_grants: got fill=%b lk=%b expected 0 0", fill_gnt, lk_gnt); end
        n_checks++; if (tagCycle !== 1'b0 || readWr !== 1'b1) begin n_fail++; $display("FAIL reset_ctl: got tagCycle=%b readWr=%b expected 0 1", tagCycle, readWr); end
        n_checks++; if (tagIndex !== 9'h000 || writeTagANotB !== 23'h7FFFFF) begin n_fail++; $display("FAIL reset_idx: got idx=%h sel=%h expected 000 7fffff", tagIndex, writeTagANotB); end
        n_checks++; if (dataIn !== 22'h0 || dataInParityBit !== 1'b0) begin n_fail++; $display("FAIL reset_data: got %h/%b expected 0/0", dataIn, dataInParityBit); end
        n_checks++; if (lk_vld !== 1'b0 || inv_busy !== 1'b0 || inv_done !== 1'b0) begin n_fail++; $display("FAIL reset_state: got vld=%b busy=%b done=%b expected 0 0 0", lk_vld, inv_busy, inv_done); end
        fill_req = 1'b0; lk_req = 1'b0;
        reset = 1'b0;
        @(negedge CB);
    endtask

    task automatic test_fill_lookup();
        @(negedge CB);
        fill_req = 1'b1; fill_idx = 9'h05A; fill_wayA = 1'b1; fill_tag = 22'h2AAAAA;
        #1;
        n_checks++; if (fill_gnt !== 1'b1) begin n_fail++; $display("FAIL fill_gnt: got %b expected 1", fill_gnt); end
        n_checks++; if (tagCycle !== 1'b1 || readWr !== 1'b0 || tagIndex !== 9'h05A) begin n_fail++; $display("FAIL fill_ctl: got cyc=%b rw=%b idx=%h expected 1 0 05a", tagCycle, readWr, tagIndex); end
        n_checks++; if (writeTagANotB !== 23'h7FFFFF || dataIn !== 22'h2AAAAA) begin n_fail++; $display("FAIL fill_data: got sel=%h data=%h expected 7fffff 2aaaaa", writeTagANotB, dataIn); end
        n_checks++; if (dataInParityBit !== PAR_ON) begin n_fail++; $display("FAIL fill_par: got %b expected %b", dataInParityBit, PAR_ON); end
        @(negedge CB);
        fill_req = 1'b0; lk_req = 1'b1; lk_idx = 9'h05A;
        #1;
        n_checks++; if (lk_gnt !== 1'b1 || readWr !== 1'b1 || tagIndex !== 9'h05A || tagCycle !== 1'b1) begin n_fail++; $display("FAIL lk_issue: got gnt=%b rw=%b idx=%h cyc=%b expected 1 1 05a 1", lk_gnt, readWr, tagIndex, tagCycle); end
        n_checks++; if (lk_vld !== 1'b0) begin n_fail++; $display("FAIL lk_vld_early: got %b expected 0", lk_vld); end
        @(negedge CB);
        lk_req = 1'b0;
        #1;
        n_checks++; if (lk_vld !== 1'b1 || lk_tagA !== 22'h2AAAAA) begin n_fail++; $display("FAIL lk_result: got vld=%b tagA=%h expected 1 2aaaaa", lk_vld, lk_tagA); end
        n_checks++; if (lk_par_err !== 2'b00) begin n_fail++; $display("FAIL lk_par_clean: got %b expected 00", lk_par_err); end
        @(negedge CB);
        #1;
        n_checks++; if (lk_vld !== 1'b0) begin n_fail++; $display("FAIL lk_vld_pulse: got %b expected 0", lk_vld); end
    endtask

    task automatic test_priority();
        @(negedge CB);
        fill_req = 1'b1; fill_idx = 9'h033; fill_wayA = 1'b0; fill_tag = 22'h123456;
        lk_req = 1'b1; lk_idx = 9'h033;
        #1;
        n_checks++; if (fill_gnt !== 1'b1 || lk_gnt !== 1'b0) begin n_fail++; $display("FAIL prio_fill: got fill=%b lk=%b expected 1 0", fill_gnt, lk_gnt); end
        n_checks++; if (writeTagANotB !== 23'h000000 || dataIn !== 22'h123456) begin n_fail++; $display("FAIL prio_wayb: got sel=%h data=%h expected 000000 123456", writeTagANotB, dataIn); end
        @(negedge CB);
        fill_req = 1'b0;
        #1;
        n_checks++; if (lk_gnt !== 1'b1 || fill_gnt !== 1'b0) begin n_fail++; $display("FAIL prio_lk_next: got lk=%b fill=%b expected 1 0", lk_gnt, fill_gnt); end
        @(negedge CB);
        lk_req = 1'b0;
        #1;
        n_checks++; if (lk_vld !== 1'b1 || lk_tagB !== 22'h123456) begin n_fail++; $display("FAIL prio_result: got vld=%b tagB=%h expected 1 123456", lk_vld, lk_tagB); end
        n_checks++; if (lk_tagA !== 22'h155566) begin n_fail++; $display("FAIL prio_wayA_kept: got %h expected 155566", lk_tagA); end
    endtask

    task automatic lookup_zero(input logic [8:0] idx);
        @(negedge CB);
        lk_req = 1'b1; lk_idx = idx;
        @(negedge CB);
        lk_req = 1'b0;
        #1;
        n_checks++; if (lk_vld !== 1'b1 || lk_tagA !== 22'h0 || lk_tagB !== 22'h0 || lk_par_err !== 2'b00) begin n_fail++; $display("FAIL swept_read_%h: got vld=%b A=%h B=%h perr=%b expected 1 0 0 00", idx, lk_vld, lk_tagA, lk_tagB, lk_par_err); end
    endtask

    task automatic test_sweep();
        int bad = 0;
        int busy = 0;
        int dones = 0;
        @(negedge CB);
        inv_start = 1'b1;
        #1;
        n_checks++; if (inv_busy !== 1'b0 || tagCycle !== 1'b0) begin n_fail++; $display("FAIL sweep_start_cycle: got busy=%b cyc=%b expected 0 0", inv_busy, tagCycle); end
        for (int k = 0; k < 512; k++) begin
            @(negedge CB);
            inv_start = (k == 200);
            #1;
            if (inv_busy) busy++;
            if (inv_done) dones++;
            if (tagCycle !== 1'b1 || readWr !== 1'b0 || tagIndex !== 9'(k / 2) || dataIn !== 22'h0
                || dataInParityBit !== 1'b0 || writeTagANotB !== ((k % 2 == 0) ? 23'h7FFFFF : 23'h000000)) begin
                if (bad < 3) $display("sweep step %0d: idx=%h sel=%h cyc=%b rw=%b", k, tagIndex, writeTagANotB, tagCycle, readWr);
                bad++;
            end
        end
        inv_start = 1'b0;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL sweep_writes: got %0d bad steps expected 0", bad); end
        @(negedge CB);
        #1;
        if (inv_busy) busy++;
        n_checks++; if (inv_done !== 1'b1 || tagCycle !== 1'b0) begin n_fail++; $display("FAIL sweep_done: got done=%b cyc=%b expected 1 0", inv_done, tagCycle); end
        @(negedge CB);
        #1;
        if (inv_busy) busy++;
        if (inv_done) dones++;
        n_checks++; if (busy !== 513) begin n_fail++; $display("FAIL sweep_busy_len: got %0d expected 513", busy); end
        n_checks++; if (dones !== 0 || inv_busy !== 1'b0) begin n_fail++; $display("FAIL sweep_end: got extra done=%0d busy=%b expected 0 0", dones, inv_busy); end
        lookup_zero(9'h05A);
        lookup_zero(9'h033);
        lookup_zero(9'h0FF);
        lookup_zero(9'h000);
    endtask

    task automatic test_sweep_blocks();
        int grants = 0;
        @(negedge CB);
        fill_req = 1'b1; fill_idx = 9'h044; fill_wayA = 1'b1; fill_tag = 22'h3FFFFF;
        #1;
        fill_req = 1'b1;
        @(negedge CB);
        fill_req = 1'b0;
        lk_req = 1'b1; lk_idx = 9'h044; inv_start = 1'b1;
        #1;
        n_checks++; if (lk_gnt !== 1'b1) begin n_fail++; $display("FAIL blk_same_cycle_lk: got %b expected 1", lk_gnt); end
        @(negedge CB);
        inv_start = 1'b0;
        fill_req = 1'b1; fill_idx = 9'h044; fill_wayA = 1'b0; fill_tag = 22'h0F0F0F;
        lk_req = 1'b1;
        #1;
        n_checks++; if (lk_vld !== 1'b1 || inv_busy !== 1'b1) begin n_fail++; $display("FAIL blk_vld_survives: got vld=%b busy=%b expected 1 1", lk_vld, inv_busy); end
        for (int k = 0; k < 513; k++) begin
            if (k > 0) begin @(negedge CB); #1; end
            if (fill_gnt || lk_gnt) grants++;
        end
        n_checks++; if (grants !== 0) begin n_fail++; $display("FAIL blk_no_grants: got %0d grants expected 0", grants); end
        @(negedge CB);
        #1;
        n_checks++; if (fill_gnt !== 1'b1 || lk_gnt !== 1'b0 || inv_busy !== 1'b0) begin n_fail++; $display("FAIL blk_fill_first: got fill=%b lk=%b busy=%b expected 1 0 0", fill_gnt, lk_gnt, inv_busy); end
        @(negedge CB);
        fill_req = 1'b0;
        #1;
        n_checks++; if (lk_gnt !== 1'b1) begin n_fail++; $display("FAIL blk_lk_second: got %b expected 1", lk_gnt); end
        @(negedge CB);
        lk_req = 1'b0;
        #1;
        n_checks++; if (lk_vld !== 1'b1 || lk_tagA !== 22'h0 || lk_tagB !== 22'h0F0F0F) begin n_fail++; $display("FAIL blk_result: got vld=%b A=%h B=%h expected 1 0 0f0f0f", lk_vld, lk_tagA, lk_tagB); end
    endtask

    task automatic test_reset_mid_sweep();
        logic found = 1'b0;
        int dones = 0;
        @(negedge CB);
        inv_start = 1'b1;
        @(negedge CB);
        inv_start = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            #1;
            if (tagIndex === 9'd100 && writeTagANotB === 23'h7FFFFF && tagCycle === 1'b1) found = 1'b1;
            else @(negedge CB);
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rst_reach_set100: got not reached expected reached"); end
        reset = 1'b1;
        #1;
        n_checks++; if (inv_busy !== 1'b0 || tagCycle !== 1'b0 || inv_done !== 1'b0) begin n_fail++; $display("FAIL rst_async: got busy=%b cyc=%b done=%b expected 0 0 0", inv_busy, tagCycle, inv_done); end
        n_checks++; if (tagIndex !== 9'h000 || writeTagANotB !== 23'h7FFFFF || readWr !== 1'b1) begin n_fail++; $display("FAIL rst_pins: got idx=%h sel=%h rw=%b expected 000 7fffff 1", tagIndex, writeTagANotB, readWr); end
        @(negedge CB);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CB); #1;
            if (inv_done || inv_busy || tagCycle) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL rst_quiet: got %0d active cycles expected 0", dones); end
        inv_start = 1'b1;
        @(negedge CB);
        inv_start = 1'b0;
        #1;
        n_checks++; if (inv_busy !== 1'b1 || tagIndex !== 9'h000 || writeTagANotB !== 23'h7FFFFF || tagCycle !== 1'b1) begin n_fail++; $display("FAIL rst_restart: got busy=%b idx=%h sel=%h cyc=%b expected 1 000 7fffff 1", inv_busy, tagIndex, writeTagANotB, tagCycle); end
        @(negedge CB);
        #1;
        n_checks++; if (tagIndex !== 9'h000 || writeTagANotB !== 23'h000000) begin n_fail++; $display("FAIL rst_restart_b: got idx=%h sel=%h expected 000 000000", tagIndex, writeTagANotB); end
        reset = 1'b1;
        @(negedge CB);
        reset = 1'b0;
    endtask

    task automatic test_parity();
        @(negedge CB);
        fill_req = 1'b1; fill_idx = 9'h010; fill_wayA = 1'b0; fill_tag = 22'h000003;
        #1;
        n_checks++; if (dataInParityBit !== 1'b0) begin n_fail++; $display("FAIL par_fill_even: got %b expected 0", dataInParityBit); end
        @(negedge CB);
        fill_idx = 9'h011; fill_wayA = 1'b1; fill_tag = 22'h000001;
        #1;
        n_checks++; if (dataInParityBit !== PAR_ON) begin n_fail++; $display("FAIL par_fill_odd: got %b expected %b", dataInParityBit, PAR_ON); end
        @(negedge CB);
        fill_req = 1'b0;
        lk_req = 1'b1; lk_idx = 9'h010; flip_b = 1'b1;
        @(negedge CB);
        lk_req = 1'b0;
        #1;
        n_checks++; if (lk_vld !== 1'b1 || lk_par_err !== {PAR_ON, 1'b0}) begin n_fail++; $display("FAIL par_flip_b: got vld=%b perr=%b expected 1 %b0", lk_vld, lk_par_err, PAR_ON); end
        @(negedge CB);
        #1;
        n_checks++; if (lk_par_err !== 2'b00) begin n_fail++; $display("FAIL par_qualified: got %b expected 00", lk_par_err); end
        flip_b = 1'b0;
        lk_req = 1'b1; lk_idx = 9'h011;
        @(negedge CB);
        lk_req = 1'b0;
        #1;
        n_checks++; if (lk_vld !== 1'b1 || lk_tagA !== 22'h000001 || lk_par_err !== 2'b00) begin n_fail++; $display("FAIL par_good_a: got vld=%b A=%h perr=%b expected 1 000001 00", lk_vld, lk_tagA, lk_par_err); end
    endtask

    initial begin
        test_reset();
        test_fill_lookup();
        test_priority();
        test_sweep();
        test_sweep_blocks();
        test_reset_mid_sweep();
        test_parity();
        repeat (2) @(negedge CB);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
